// File: rtl/grf_write_arbiter.sv
// rtl/grf_write_arbiter.sv - single GRF write port shared by writeback and a buffered aux result stream
module grf_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_we,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    input  logic [31:0]      wb_pc,
    input  logic             aux_valid,
    output logic             aux_ready,
    input  logic [4:0]       aux_addr,
    input  logic [31:0]      aux_data,
    input  logic [31:0]      aux_pc,
    output logic             grf_we,
    output logic [4:0]       grf_addr,
    output logic [31:0]      grf_data,
    output logic [31:0]      grf_pc,
    output logic [31:0]      busy_mask,
    output logic [PTR_W:0]   pending_count
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic wb_act;
    logic aux_acc;
    logic enq;
    logic deq;

    assign wb_act    = wb_we && (wb_addr != 5'd0);
    assign aux_ready = !reset && (count < FULL);
    assign aux_acc   = aux_valid && aux_ready;

    always_comb begin
        grf_we   = 1'b0;
        grf_addr = 5'd0;
        grf_data = 32'd0;
        grf_pc   = 32'd0;
        enq      = 1'b0;
        deq      = 1'b0;
        if (!reset) begin
            if (wb_act) begin
                grf_we   = 1'b1;
                grf_addr = wb_addr;
                grf_data = wb_data;
                grf_pc   = wb_pc;
                enq      = aux_acc && (aux_addr != 5'd0);
            end else if (count != '0) begin
                grf_we   = 1'b1;
                grf_addr = addr_q[rd_ptr];
                grf_data = data_q[rd_ptr];
                grf_pc   = pc_q[rd_ptr];
                deq      = 1'b1;
                enq      = aux_acc && (aux_addr != 5'd0);
            end else if (aux_acc && (aux_addr != 5'd0)) begin
                // Empty FIFO: hand the aux result straight to the port.
                grf_we   = 1'b1;
                grf_addr = aux_addr;
                grf_data = aux_data;
                grf_pc   = aux_pc;
            end
        end
    end

    // Walk the occupied window starting at the head; entries beyond count are stale.
    always_comb begin
        busy_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PTR_W+1)'(i) < count)
                busy_mask[addr_q[rd_ptr + PTR_W'(i)]] = 1'b1;
        end
        busy_mask[0] = 1'b0;
        if (reset)
            busy_mask = 32'd0;
    end

    assign pending_count = reset ? '0 : count;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            if (enq && !deq)
                count <= count + 1'b1;
            else if (deq && !enq)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            addr_q[wr_ptr] <= aux_addr;
            data_q[wr_ptr] <= aux_data;
            pc_q[wr_ptr]   <= aux_pc;
        end
    end

endmodule
